// File: rtl/asoc_readout_sequencer_if.sv
// Read-request handshake between the readout sequencer and the readout datapath.
//   rd_req  : window read request (sequencer -> datapath)
//   rd_ch   : channel of the current request
//   rd_win  : window index of the current request
//   rd_ack  : datapath accepted the request (datapath -> sequencer)
//   rd_done : datapath finished the current window
// Modports: master = sequencer side, slave = datapath side.
interface asoc_readout_sequencer_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIN_W = 5
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              rd_req;
    logic [CH_W-1:0]   rd_ch;
    logic [WIN_W-1:0]  rd_win;
    logic              rd_ack;
    logic              rd_done;

    modport master (
        output rd_req, rd_ch, rd_win,
        input  rd_ack, rd_done
    );

    modport slave (
        input  rd_req, rd_ch, rd_win,
        output rd_ack, rd_done
    );
endinterface

// File: rtl/asoc_readout_sequencer.sv
// ASOC readout sequencer: on an accepted trigger, waits trig_delay cycles and
// then issues one read request per window for every channel set in the
// latched mask (lowest channel first), counting completed events.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   enable, trig_in : trigger acceptance enable and trigger request
//   ch_mask         : channels to read (bit i = channel i)
//   num_win         : windows per channel
//   trig_delay      : cycles from trigger to first read
//   rd              : read handshake interface (master modport)
//   busy            : event in progress
//   evt_start       : one-cycle pulse, event accepted
//   evt_end         : one-cycle pulse, event finished
//   trig_drop       : one-cycle pulse, trigger ignored
//   evt_cnt         : completed-event counter (wraps at 2^16)
//   timeout_err     : sticky rd_done timeout flag
//
// Build option: define ASOC_RDO_TIMEOUT_EN to enable the rd_done timeout
// (TO_CYC cycles in WAIT aborts the event). Without it timeout_err is 0 and
// WAIT waits indefinitely.
module asoc_readout_sequencer #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned WIN_W  = 5,
    parameter int unsigned TO_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                trig_in,
    input  logic [N_CH-1:0]     ch_mask,
    input  logic [WIN_W-1:0]    num_win,
    input  logic [7:0]          trig_delay,
    asoc_readout_sequencer_if.master rd,
    output logic                busy,
    output logic                evt_start,
    output logic                evt_end,
    output logic                trig_drop,
    output logic [15:0]         evt_cnt,
    output logic                timeout_err
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned TO_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    if (TO_CYC < 1) begin : g_to_cyc_check
        $error("TO_CYC must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, DELAY, SELECT, REQ, WAIT, END} state_t;

    state_t            state_q, state_d;
    logic [7:0]        dly_q, dly_d;
    logic [N_CH-1:0]   pend_q, pend_d;     // latched mask, visited channels cleared
    logic [WIN_W-1:0]  nwin_q, nwin_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              start_q, start_d;
    logic              drop_q, drop_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              accept;
    logic              last_win;
    logic              complete;
    logic              found;
`ifdef ASOC_RDO_TIMEOUT_EN
    logic [TO_W-1:0]   to_q, to_d;
    logic              tout_q, tout_d;
`endif

    assign accept   = trig_in & enable & (|ch_mask) & (|num_win);
    // Widened compare so num_win-1 never underflows.
    assign last_win = ({1'b0, win_q} + {{WIN_W{1'b0}}, 1'b1}) >= {1'b0, nwin_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dly_q   <= '0;
            pend_q  <= '0;
            nwin_q  <= '0;
            win_q   <= '0;
            ch_q    <= '0;
            start_q <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef ASOC_RDO_TIMEOUT_EN
            to_q    <= '0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            pend_q  <= pend_d;
            nwin_q  <= nwin_d;
            win_q   <= win_d;
            ch_q    <= ch_d;
            start_q <= start_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
`ifdef ASOC_RDO_TIMEOUT_EN
            to_q    <= to_d;
            tout_q  <= tout_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        pend_d   = pend_q;
        nwin_d   = nwin_q;
        win_d    = win_q;
        ch_d     = ch_q;
        start_d  = 1'b0;
        drop_d   = 1'b0;
        cnt_d    = cnt_q;
        complete = 1'b0;
        found    = 1'b0;
`ifdef ASOC_RDO_TIMEOUT_EN
        to_d     = to_q;
        tout_d   = tout_q;
`endif
        // Any trigger outside IDLE is refused without touching the event.
        if (state_q != IDLE) begin
            drop_d = trig_in;
        end

        case (state_q)
            IDLE: begin
                if (trig_in) begin
                    if (accept) begin
                        pend_d  = ch_mask;
                        nwin_d  = num_win;
                        dly_d   = trig_delay;
                        start_d = 1'b1;
                        state_d = DELAY;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (dly_q == 8'd0) begin
                    state_d = SELECT;
                end else begin
                    dly_d = dly_q - 8'd1;
                end
            end
            SELECT: begin
                win_d = '0;
                for (int unsigned i = 0; i < N_CH; i++) begin
                    if (!found && pend_q[i]) begin
                        found     = 1'b1;
                        ch_d      = CH_W'(i);
                        pend_d[i] = 1'b0;
                    end
                end
                state_d = found ? REQ : END;
            end
            REQ: begin
                if (rd.rd_ack) begin
                    if (rd.rd_done) begin
                        complete = 1'b1;
                    end else begin
                        state_d = WAIT;
`ifdef ASOC_RDO_TIMEOUT_EN
                        to_d    = '0;
`endif
                    end
                end
            end
            WAIT: begin
                if (rd.rd_done) begin
                    complete = 1'b1;
                end
`ifdef ASOC_RDO_TIMEOUT_EN
                else if (to_q == TO_W'(TO_CYC - 1)) begin
                    tout_d  = 1'b1;
                    state_d = END;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
`endif
            end
            END: begin
                cnt_d   = cnt_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Window completion from REQ (ack+done together) or WAIT share one path.
        if (complete) begin
            if (last_win) begin
                state_d = SELECT;
            end else begin
                win_d   = win_q + {{(WIN_W-1){1'b0}}, 1'b1};
                state_d = REQ;
            end
        end
    end

    assign rd.rd_req = (state_q == REQ);
    assign rd.rd_ch  = ch_q;
    assign rd.rd_win = win_q;
    assign busy      = (state_q != IDLE);
    assign evt_start = start_q;
    assign evt_end   = (state_q == END);
    assign trig_drop = drop_q;
    assign evt_cnt   = cnt_q;
`ifdef ASOC_RDO_TIMEOUT_EN
    assign timeout_err = tout_q;
`else
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_asoc_readout_sequencer.sv
// Scoreboard bench for asoc_readout_sequencer: stimulus pushes expected
// requests, pulses, first-request cycles and event counts into queues; a
// negedge monitor pops and compares whenever the DUT presents them.
module tb_asoc_readout_sequencer;
    localparam int unsigned N_CH  = 4;
    localparam int unsigned WIN_W = 5;
    localparam int unsigned TB_TO = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              trig_in = 1'b0;
    logic [N_CH-1:0]   ch_mask = '0;
    logic [WIN_W-1:0]  num_win = '0;
    logic [7:0]        trig_delay = '0;
    logic              busy, evt_start, evt_end, trig_drop, timeout_err;
    logic [15:0]       evt_cnt;

    asoc_readout_sequencer_if #(.N_CH(N_CH), .WIN_W(WIN_W)) rd_if ();

    asoc_readout_sequencer #(.N_CH(N_CH), .WIN_W(WIN_W), .TO_CYC(TB_TO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .trig_in(trig_in),
        .ch_mask(ch_mask), .num_win(num_win), .trig_delay(trig_delay),
        .rd(rd_if.master), .busy(busy), .evt_start(evt_start),
        .evt_end(evt_end), .trig_drop(trig_drop), .evt_cnt(evt_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int ch; int win; } req_t;
    typedef struct { bit drop; int cyc; } pulse_t;
    req_t   exp_req_q[$];
    pulse_t exp_pulse_q[$];
    int     exp_first_q[$];
    int     exp_end_q[$];
    int     ends_seen = 0;
    int     model_cnt = 0;

    // Datapath model: ack after dp_ack_dly cycles, done dp_done_dly cycles
    // after ack (0 = same cycle as ack, -1 = never).
    int dp_ack_dly = 1, dp_done_dly = 1, dp_phase = 0, dp_cnt = 0, ack_cyc = 0;
    bit dp_random = 0;

    initial begin
        int dd;
        rd_if.rd_ack  = 1'b0;
        rd_if.rd_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            rd_if.rd_ack  = 1'b0;
            rd_if.rd_done = 1'b0;
            if (rst) begin
                dp_phase = 0;
            end else begin
                case (dp_phase)
                    0: if (rd_if.rd_req) begin
                        dp_cnt   = dp_random ? int'($urandom_range(1, 3)) : dp_ack_dly;
                        dp_phase = 1;
                    end
                    1: begin
                        dp_cnt--;
                        if (dp_cnt == 0) begin
                            rd_if.rd_ack = 1'b1;
                            ack_cyc = cyc;
                            dd = dp_random ? int'($urandom_range(0, 3)) : dp_done_dly;
                            if (dd == 0) begin
                                rd_if.rd_done = 1'b1;
                                dp_phase = 0;
                            end else begin
                                dp_cnt   = dd;
                                dp_phase = 2;
                            end
                        end
                    end
                    default: if (dp_cnt > 0) begin
                        dp_cnt--;
                        if (dp_cnt == 0) begin
                            rd_if.rd_done = 1'b1;
                            dp_phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor
    initial begin
        bit              first_pend = 0, cnt_chk = 0, prev_req = 0, prev_hs = 0;
        int              cnt_exp = 0;
        logic [1:0]      prev_ch = '0;
        logic [WIN_W-1:0] prev_win = '0;
        pulse_t          p;
        req_t            r;
        forever begin
            @(negedge clk);
            if (rst) begin
                first_pend = 0; cnt_chk = 0; prev_req = 0; prev_hs = 0;
            end else begin
                if (cnt_chk) begin
                    check("evt_cnt", evt_cnt, cnt_exp);
                    cnt_chk = 0;
                end
                if (evt_start || trig_drop) begin
                    check("pulse_expected", exp_pulse_q.size() > 0, 1);
                    if (exp_pulse_q.size() > 0) begin
                        p = exp_pulse_q.pop_front();
                        check("pulse_is_drop", trig_drop, p.drop);
                        check("pulse_is_start", evt_start, !p.drop);
                        check("pulse_cycle", cyc, p.cyc);
                    end
                    if (evt_start) first_pend = 1;
                end
                if (rd_if.rd_req && first_pend) begin
                    first_pend = 0;
                    check("first_req_expected", exp_first_q.size() > 0, 1);
                    if (exp_first_q.size() > 0) check("first_req_cycle", cyc, exp_first_q.pop_front());
                end
                if (prev_req && !prev_hs && rd_if.rd_req) begin
                    check("rd_ch_stable", rd_if.rd_ch, prev_ch);
                    check("rd_win_stable", rd_if.rd_win, prev_win);
                end
                if (rd_if.rd_req && rd_if.rd_ack) begin
                    check("req_expected", exp_req_q.size() > 0, 1);
                    if (exp_req_q.size() > 0) begin
                        r = exp_req_q.pop_front();
                        check("rd_ch", rd_if.rd_ch, r.ch);
                        check("rd_win", rd_if.rd_win, r.win);
                    end
                end
                if (evt_end) begin
                    check("reqs_left_at_end", exp_req_q.size(), 0);
                    check("end_expected", exp_end_q.size() > 0, 1);
                    if (exp_end_q.size() > 0) begin
                        cnt_exp = exp_end_q.pop_front();
                        cnt_chk = 1;
                    end
                    ends_seen++;
                end
                prev_req = rd_if.rd_req;
                prev_hs  = rd_if.rd_ack;
                prev_ch  = rd_if.rd_ch;
                prev_win = rd_if.rd_win;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic flush();
        exp_req_q.delete(); exp_pulse_q.delete(); exp_first_q.delete(); exp_end_q.delete();
        model_cnt = 0;
    endtask

    // Issues a trigger while the DUT is idle; the model decides acceptance.
    task automatic fire(input bit en, input logic [3:0] m, input int nw, input int d, output bit acc);
        req_t r;
        pulse_t p;
        enable = en; ch_mask = m; num_win = WIN_W'(nw); trig_delay = 8'(d); trig_in = 1'b1;
        acc = en && (m != 0) && (nw != 0);
        p.drop = !acc; p.cyc = cyc + 1;
        exp_pulse_q.push_back(p);
        if (acc) begin
            exp_first_q.push_back(cyc + 3 + d);
            for (int c = 0; c < 4; c++)
                if (m[c]) for (int w = 0; w < nw; w++) begin
                    r.ch = c; r.win = w; exp_req_q.push_back(r);
                end
            model_cnt = (model_cnt + 1) % 65536;
            exp_end_q.push_back(model_cnt);
        end
        tick();
        trig_in = 1'b0;
    endtask

    task automatic busy_trig();
        pulse_t p;
        trig_in = 1'b1;
        p.drop = 1'b1; p.cyc = cyc + 1;
        exp_pulse_q.push_back(p);
        tick();
        trig_in = 1'b0;
    endtask

    task automatic wait_ends(input int target);
        int n = 0;
        while (ends_seen < target && n < 3000) begin tick(); n++; end
        check("event_complete", ends_seen, target);
    endtask

    task automatic wait_dp_wait();
        int n = 0;
        while (dp_phase != 2 && n < 200) begin tick(); n++; end
        check("dp_reached_wait", dp_phase, 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit acc;
        int a, e0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_rd_req", rd_if.rd_req, 0);
        check("reset_evt_cnt", evt_cnt, 0);
        check("reset_timeout", timeout_err, 0);
        check("reset_rd_ch", rd_if.rd_ch, 0);
        check("reset_rd_win", rd_if.rd_win, 0);
        tick();

        // Two channels, two windows, delay 3
        dp_ack_dly = 1; dp_done_dly = 1;
        fire(1, 4'b0101, 2, 3, acc);
        wait_ends(1);
        check("evt_cnt_after_first", evt_cnt, 1);

        // Refused triggers while idle
        fire(1, 4'b0000, 2, 1, acc);
        fire(0, 4'b0101, 2, 1, acc);
        fire(1, 4'b0011, 0, 1, acc);
        for (int i = 0; i < 4; i++) begin
            check("drop_busy", busy, 0);
            check("drop_rd_req", rd_if.rd_req, 0);
            tick();
        end
        check("drop_evt_cnt", evt_cnt, 1);

        // Second trigger during WAIT; inputs changed mid-event
        dp_done_dly = 4;
        fire(1, 4'b0011, 1, 0, acc);
        enable = 1'b0; ch_mask = 4'b1111; num_win = 5'd3; trig_delay = 8'd9;
        wait_dp_wait();
        tick();
        busy_trig();
        wait_ends(2);

        // ack and done together on every window
        dp_done_dly = 0;
        fire(1, 4'b1000, 3, 2, acc);
        wait_ends(3);

        // Randomized events
        dp_random = 1;
        for (int n = 0; n < 30; n++) begin
            int r, d, k;
            r = $urandom_range(0, 9);
            d = $urandom_range(0, 5);
            e0 = ends_seen;
            fire(r != 0, (r == 1) ? 4'b0000 : 4'($urandom_range(1, 15)),
                 (r == 2) ? 0 : $urandom_range(1, 3), d, acc);
            enable = 1'($urandom_range(0, 1));
            ch_mask = 4'($urandom_range(0, 15));
            num_win = WIN_W'($urandom_range(0, 4));
            trig_delay = 8'($urandom_range(0, 9));
            if (acc) begin
                if ($urandom_range(0, 1) == 1) begin
                    k = $urandom_range(0, d);
                    repeat (k) tick();
                    busy_trig();
                end
                wait_ends(e0 + 1);
            end else begin
                tick();
                check("random_drop_idle", busy, 0);
            end
        end
        dp_random = 0;

        // Reset during WAIT of channel 1
        dp_ack_dly = 1; dp_done_dly = -1;
        fire(1, 4'b0010, 2, 1, acc);
        wait_dp_wait();
        tick();
        e0 = ends_seen;
        rst = 1'b1;
        flush();
        tick();
        check("rst_rd_req", rd_if.rd_req, 0);
        check("rst_busy", busy, 0);
        check("rst_evt_cnt", evt_cnt, 0);
        rst = 1'b0;
        repeat (5) tick();
        check("rst_no_evt_end", ends_seen, e0);
        check("rst_stays_idle", busy, 0);

        // rd_done withheld
        e0 = ends_seen;
        fire(1, 4'b0001, 2, 1, acc);
        wait_dp_wait();
        a = ack_cyc;
`ifdef ASOC_RDO_TIMEOUT_EN
        void'(exp_req_q.pop_back());
        while (cyc < a + 16) tick();
        check("to_before_busy", busy, 1);
        check("to_before_err", timeout_err, 0);
        tick();
        check("to_err_set", timeout_err, 1);
        check("to_evt_end", evt_end, 1);
        wait_ends(e0 + 1);
        repeat (5) tick();
        check("to_err_sticky", timeout_err, 1);
        check("to_evt_cnt", evt_cnt, 1);
`else
        while (cyc < a + 40) tick();
        check("nto_busy", busy, 1);
        check("nto_err", timeout_err, 0);
        check("nto_no_end", ends_seen, e0);
`endif
        rst = 1'b1;
        flush();
        tick();
        rst = 1'b0;
        tick();
        check("final_timeout_clear", timeout_err, 0);
        check("final_busy", busy, 0);
        repeat (3) tick();
        check("pending_expectations",
              exp_req_q.size() + exp_pulse_q.size() + exp_first_q.size() + exp_end_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/asoc_readout_sequencer.md
ASOC_READOUT_SEQUENCER -- requirements
Module: asoc_readout_sequencer

Interface
REQ-001 The block SHALL provide the following parameters:
- N_CH, default 4, number of ASOC channels.
- WIN_W, default 5, window-index width.
- TO_CYC, default 4096, rd_done timeout in clk cycles.

REQ-002 The block SHALL provide the following ports, clock and reset first:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  trigger acceptance enable.
- trig_in  in  1  trigger request, sampled each cycle.
- ch_mask  in  N_CH  channels to read; bit i = channel i.
- num_win  in  WIN_W  windows per channel.
- trig_delay  in  8  cycles from trigger to first read.
- rd_req  out  1  window read request to the readout datapath.
- rd_ch  out  clog2(N_CH)  channel of the current request.
- rd_win  out  WIN_W  window index of the current request.
- rd_ack  in  1  datapath accepted the request.
- rd_done  in  1  datapath finished the current window.
- busy  out  1  event in progress.
- evt_start  out  1  one-cycle pulse, event accepted.
- evt_end  out  1  one-cycle pulse, event finished.
- trig_drop  out  1  one-cycle pulse, trigger ignored.
- evt_cnt  out  16  completed-event counter.
- timeout_err  out  1  sticky rd_done timeout flag.

Function
REQ-003 The state machine SHALL use states IDLE, DELAY, SELECT, REQ, WAIT and END.

REQ-004 In IDLE, trig_in=1 with enable=1, ch_mask!=0 and num_win!=0 SHALL do all of the following:
- latch ch_mask, num_win and trig_delay;
- load the delay counter with trig_delay;
- enter DELAY;
- pulse evt_start in the next cycle.

REQ-005 In IDLE, trig_in=1 with enable=0, ch_mask=0 or num_win=0 SHALL pulse trig_drop and remain in IDLE.

REQ-006 trig_in=1 in any state other than IDLE SHALL pulse trig_drop and SHALL NOT affect the event in progress.

REQ-007 DELAY SHALL decrement the counter each cycle and move to SELECT when it reaches 0, so that the first rd_req rises exactly trig_delay+2 cycles after the trig_in sampling edge.

REQ-008 SELECT SHALL pick the lowest-index unvisited channel set in the latched mask, set rd_win=0 and enter REQ; if no channel remains it SHALL enter END.

REQ-009 Read handshake in REQ:
- rd_req SHALL be high, with rd_ch and rd_win held stable, until the cycle rd_ack=1.
- The state SHALL then move to WAIT and rd_req SHALL drop in the following cycle.

REQ-010 rd_ack SHALL be ignored outside REQ, and rd_done SHALL be ignored outside REQ and WAIT.

REQ-011 rd_done=1 in the same cycle as rd_ack SHALL count as window completion, skipping WAIT.

REQ-012 On window completion:
- if rd_win < num_win-1, rd_win SHALL increment and the state SHALL return to REQ;
- otherwise the state SHALL go to SELECT.

REQ-013 END SHALL last one cycle, pulse evt_end, increment evt_cnt modulo 2^16 (0xFFFF wraps to 0x0000), then return to IDLE.

REQ-014 busy SHALL be 0 in IDLE and 1 in all other states.

REQ-015 Deasserting enable mid-event SHALL NOT abort the event; it blocks only new triggers.

REQ-016 Changes to ch_mask, num_win or trig_delay during an event SHALL take effect at the next accepted trigger only.

Reset
REQ-017 While rst=1, the block SHALL:
- enter IDLE;
- drive rd_req, busy, evt_start, evt_end and trig_drop to 0;
- drive rd_ch, rd_win and evt_cnt to 0;
- clear timeout_err;
- clear the delay and timeout counters.

REQ-018 Reset asserted mid-event SHALL abandon the event with no evt_end pulse, and rd_req SHALL be 0 in the first cycle after the reset edge.

Configuration
REQ-019 With macro ASOC_RDO_TIMEOUT_EN defined:
- a counter SHALL run while in WAIT;
- if TO_CYC cycles elapse without rd_done, timeout_err SHALL set and the remaining windows and channels SHALL be skipped;
- the state SHALL go to END, with evt_end pulsed and evt_cnt incremented;
- timeout_err SHALL clear only on rst.

REQ-020 Without ASOC_RDO_TIMEOUT_EN, timeout_err SHALL be constant 0 and WAIT SHALL wait indefinitely for rd_done.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- ch_mask=4'b0101, num_win=2, trig_delay=3, rd_ack and rd_done one cycle after each request -> requests (0,0),(0,1),(2,0),(2,1) in order; first rd_req 5 cycles after trigger; one evt_end; evt_cnt=1.
- Trigger with ch_mask=0 or with enable=0 -> trig_drop pulse, busy stays 0, no rd_req, evt_cnt unchanged.
- Second trig_in during WAIT -> trig_drop pulse; first event completes unchanged.
- rd_ack and rd_done high in the same cycle on every window, ch_mask=4'b1000, num_win=3 -> three requests, rd_win 0,1,2, evt_end, no stall.
- rst asserted during WAIT of channel 1 -> next cycle rd_req=0, busy=0, evt_cnt=0, no evt_end.
- ASOC_RDO_TIMEOUT_EN defined, TO_CYC=16, rd_done withheld -> timeout_err=1 after 16 WAIT cycles, evt_end pulse, evt_cnt=1; undefined build -> stays in WAIT, timeout_err=0.
